// File: rtl/exu_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : exu_dispatch_if
// Description : Bundle that carries the IFU push handshake and the EXU
//               handler dispatch bus between the dispatcher and its
//               neighbours.
//               IFU side     : in_vld, in_rdy, in_inst, in_pc
//               Handler side : alu_sel, br_sel, lsu_sel, misc_sel, inst, pc,
//                              lsu_done, flush, ill_inst
//               The "slave" modport is the dispatcher. The "master" modport
//               is the surrounding IFU and handlers.
// Revision    : 1.0 - initial release
// ============================================================================
interface exu_dispatch_if #(
   parameter int RV_XLEN = 32
);
   logic               in_vld;
   logic               in_rdy;
   logic [31:0]        in_inst;
   logic [RV_XLEN-1:0] in_pc;
   logic               alu_sel;
   logic               br_sel;
   logic               lsu_sel;
   logic               misc_sel;
   logic [31:0]        inst;
   logic [RV_XLEN-1:0] pc;
   logic               lsu_done;
   logic               flush;
   logic               ill_inst;

   modport slave (
      input  in_vld, in_inst, in_pc, lsu_done, flush,
      output in_rdy, alu_sel, br_sel, lsu_sel, misc_sel, inst, pc, ill_inst
   );

   modport master (
      output in_vld, in_inst, in_pc, lsu_done, flush,
      input  in_rdy, alu_sel, br_sel, lsu_sel, misc_sel, inst, pc, ill_inst
   );
endinterface
`default_nettype wire

// File: rtl/exu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : exu_dispatch
// Description : Instruction buffer and dispatcher in front of the EXU
//               handlers. Fetched instructions are queued in a DEPTH-entry
//               FIFO. The head entry is decoded combinationally and steered
//               to exactly one of the ALU, branch, LSU or misc handlers, or
//               dropped with a one-cycle ill_inst pulse. An LSU op is held
//               at the head until lsu_done. A branch redirect (flush with
//               br_sel) empties the buffer.
// Ports       : clk       - clock
//               rst_n     - synchronous reset, active low
//               bus       - exu_dispatch_if.slave (IFU push + handler bus)
//               perf_issue- legal-instruction issue count
//                           (only with EXU_DISPATCH_PERF_EN)
//               perf_stall- LSU wait cycles without lsu_done
//                           (only with EXU_DISPATCH_PERF_EN)
// Options     : define EXU_DISPATCH_PERF_EN to add the performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module exu_dispatch #(
   parameter int DEPTH   = 2,
   parameter int RV_XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   exu_dispatch_if.slave  bus
`ifdef EXU_DISPATCH_PERF_EN
   ,
   output logic [31:0]    perf_issue,
   output logic [31:0]    perf_stall
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ALUI   = 7'b0010011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_LSU = 1'b1
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [31:0]        r_inst_mem [DEPTH];
   logic [RV_XLEN-1:0] r_pc_mem   [DEPTH];

   logic               w_empty;
   logic [31:0]        w_head_inst;
   logic [RV_XLEN-1:0] w_head_pc;
   logic               w_is_alu;
   logic               w_is_br;
   logic               w_is_lsu;
   logic               w_is_misc;
   logic               w_is_ill;
   logic               w_push;
   logic               w_pop;
   logic               w_flush;

   assign w_empty     = (r_count == '0);
   assign w_head_inst = w_empty ? '0 : r_inst_mem[r_rd_ptr];
   assign w_head_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];

   // Head decode. Every non-empty head lands in exactly one class.
   always_comb begin
      w_is_alu  = 1'b0;
      w_is_br   = 1'b0;
      w_is_lsu  = 1'b0;
      w_is_misc = 1'b0;
      w_is_ill  = 1'b0;
      if (!w_empty) begin
         case (w_head_inst[6:0])
            OPC_ALU, OPC_ALUI:                          w_is_alu  = 1'b1;
            OPC_JAL, OPC_JALR, OPC_BRANCH:              w_is_br   = 1'b1;
            OPC_LOAD, OPC_STORE:                        w_is_lsu  = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM:  w_is_misc = 1'b1;
            default:                                    w_is_ill  = 1'b1;
         endcase
      end
   end

   // in_rdy depends only on the registered count, so there is no
   // combinational path from lsu_done or the sel outputs.
   assign bus.in_rdy   = (r_count != CNT_W'(DEPTH));
   assign bus.alu_sel  = w_is_alu;
   assign bus.br_sel   = w_is_br;
   // While waiting, the head cannot change, so the LSU decode stays high.
   assign bus.lsu_sel  = w_is_lsu;
   assign bus.misc_sel = w_is_misc;
   assign bus.ill_inst = w_is_ill;
   assign bus.inst     = w_head_inst;
   assign bus.pc       = w_head_pc;

   assign w_push  = bus.in_vld && bus.in_rdy;
   assign w_pop   = w_is_alu || w_is_br || w_is_misc || w_is_ill ||
                    (w_is_lsu && bus.lsu_done);
   // A redirect is honoured only together with a branch issue. br_sel is
   // never high in ST_WAIT_LSU, so a flush there is ignored.
   assign w_flush = bus.flush && w_is_br && (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         // The branch pops, younger entries and any same-cycle push are lost.
         r_state  <= ST_IDLE;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         case (r_state)
            ST_IDLE:     if (w_is_lsu && !bus.lsu_done) r_state <= ST_WAIT_LSU;
            ST_WAIT_LSU: if (bus.lsu_done)              r_state <= ST_IDLE;
            default:                                    r_state <= ST_IDLE;
         endcase
      end
   end

   // Storage is not reset; entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (w_push && !w_flush) begin
         r_inst_mem[r_wr_ptr] <= bus.in_inst;
         r_pc_mem[r_wr_ptr]   <= bus.in_pc;
      end
   end

`ifdef EXU_DISPATCH_PERF_EN
   logic [31:0] r_perf_issue;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_issue <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_pop && !w_is_ill) begin
            r_perf_issue <= r_perf_issue + 32'd1;
         end
         if ((r_state == ST_WAIT_LSU) && !bus.lsu_done) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_issue = r_perf_issue;
   assign perf_stall = r_perf_stall;
`endif

   // A redirect is only meaningful in the cycle a branch is issued.
   a_flush_with_br : assert property (@(posedge clk) disable iff (!rst_n)
                                      bus.flush |-> bus.br_sel);

endmodule
`default_nettype wire
